// File: rtl/vr_pkg.sv
// vr_pkg: shared widths, requester ids and index decode for the vecreg port scheduler
package vr_pkg;
    localparam int VR_IND_WTH  = 4;
    localparam int VR_DATA_WTH = 2048;
    localparam int VR_IND_SIZE = 1 << VR_IND_WTH;
    localparam int RQ_MPU      = 0;
    localparam int RQ_VPU      = 1;

    typedef logic [VR_IND_WTH-1:0]  vr_idx_t;
    typedef logic [VR_DATA_WTH-1:0] vr_data_t;
    typedef logic [VR_IND_SIZE-1:0] vr_mask_t;

    function automatic vr_mask_t dec_bin_to_onehot(input vr_idx_t b);
        return VR_IND_SIZE'(1) << b;
    endfunction
endpackage

// File: rtl/vr_rr_arb2.sv
// vr_rr_arb2: two-way round-robin arbiter; on a tie the requester not granted last wins
module vr_rr_arb2
    import vr_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_vpu;

    // a lone requester always wins; a tie goes to the side that did not win last
    always_comb begin
        gnt[RQ_MPU] = req[RQ_MPU] & (~req[RQ_VPU] | last_vpu);
        gnt[RQ_VPU] = req[RQ_VPU] & (~req[RQ_MPU] | ~last_vpu);
    end

    // pointer starts at "last = VPU" so MPU takes the first tie, and moves only on a grant
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i)
            last_vpu <= 1'b1;
        else if (|gnt)
            last_vpu <= gnt[RQ_VPU];
endmodule

// File: rtl/vr_port_sched.sv
// vr_port_sched: shares the vecreg write port between MPU and VPU and stalls reads/reservations on pending writes
module vr_port_sched
    import vr_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  mpu_wreq_i,
    input  logic [VR_IND_WTH-1:0] mpu_windex_i,
    input  logic [VR_DATA_WTH-1:0] mpu_wdata_i,
    output logic                  mpu_wgnt_o,
    input  logic                  vpu_wreq_i,
    input  logic [VR_IND_WTH-1:0] vpu_windex_i,
    input  logic [VR_DATA_WTH-1:0] vpu_wdata_i,
    output logic                  vpu_wgnt_o,
    input  logic                  rsv_req_i,
    input  logic [VR_IND_WTH-1:0] rsv_index_i,
    output logic                  rsv_gnt_o,
    input  logic                  rd_req_i,
    input  logic [VR_IND_WTH-1:0] rd_index_i,
    output logic                  rd_gnt_o,
    output logic                  vr_we_o,
    output logic [VR_IND_WTH-1:0] vr_windex_o,
    output logic [VR_DATA_WTH-1:0] vr_wdata_o,
    output logic                  vr_re_o,
    output logic [VR_IND_WTH-1:0] vr_rindex_o,
    output logic [VR_IND_WTH:0]   pend_cnt_o,
    output logic                  sb_err_o
);
    logic [1:0] wgnt;
    vr_mask_t   busy, rsv_oh, rd_oh, clr_oh, set_oh, win_oh;
    vr_idx_t    widx;
    logic       wr_any, err_hit;

    vr_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req    ({vpu_wreq_i, mpu_wreq_i}),
        .gnt    (wgnt)
    );

    assign mpu_wgnt_o = wgnt[RQ_MPU];
    assign vpu_wgnt_o = wgnt[RQ_VPU];

    // hazard checks against the scoreboard; a clear landing this cycle is not yet visible here
    always_comb begin
        wr_any    = |wgnt;
        widx      = wgnt[RQ_VPU] ? vpu_windex_i : mpu_windex_i;
        rsv_oh    = dec_bin_to_onehot(rsv_index_i);
        rd_oh     = dec_bin_to_onehot(rd_index_i);
        win_oh    = dec_bin_to_onehot(widx);
        clr_oh    = vr_we_o ? dec_bin_to_onehot(vr_windex_o) : '0;
        rsv_gnt_o = rsv_req_i & ~|(busy & rsv_oh);
        rd_gnt_o  = rd_req_i & ~|(busy & rd_oh);
        set_oh    = rsv_gnt_o ? rsv_oh : '0;
        err_hit   = wr_any & ~|(busy & win_oh);
    end

    // registered write port: one-cycle pulse per grant, index/data held between writes
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            vr_we_o     <= 1'b0;
            vr_windex_o <= '0;
            vr_wdata_o  <= '0;
        end else begin
            vr_we_o <= wr_any;
            if (wr_any) begin
                vr_windex_o <= widx;
                vr_wdata_o  <= wgnt[RQ_VPU] ? vpu_wdata_i : mpu_wdata_i;
            end
        end

    // registered read enable for a granted, hazard-free source
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            vr_re_o     <= 1'b0;
            vr_rindex_o <= '0;
        end else begin
            vr_re_o <= rd_gnt_o;
            if (rd_gnt_o)
                vr_rindex_o <= rd_index_i;
        end

    // scoreboard: set wins over a clear of the same (non-busy) index; count tracks real bit changes
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            busy       <= '0;
            pend_cnt_o <= '0;
            sb_err_o   <= 1'b0;
        end else begin
            busy       <= (busy & ~clr_oh) | set_oh;
            pend_cnt_o <= pend_cnt_o + (VR_IND_WTH+1)'(|set_oh) - (VR_IND_WTH+1)'(|(clr_oh & busy));
            if (err_hit)
                sb_err_o <= 1'b1;
        end
endmodule
